// File: rtl/param_register_file.sv
// Parametrised DEPTH x DATA_W register file with byte-strobed writes and a 1-cycle pipelined read port.
// Optional per-byte-lane even parity storage and checking is enabled by defining RF_PARITY_EN.
module param_register_file #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 5,
    parameter int                DEPTH     = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = 32'hFFFF_FFFF,
    parameter logic [DATA_W-1:0] ERR_VAL   = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    output logic                  wr_err,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic                  rd_perr
);

    localparam int                NB      = DATA_W / 8;
    // One extra bit so DEPTH == 2**ADDR_W is representable and the compare never wraps.
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  wr_sel_s;
    logic [DATA_W-1:0] rd_word_s;
    logic              wr_in_range_s;
    logic              rd_in_range_s;
    logic              rd_mismatch_s;

    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic              rd_err_r;
    logic              rd_perr_r;
    logic              wr_err_r;

    // Address range decode, per-register write select and read word mux.
    always_comb begin
        wr_sel_s      = '0;
        rd_word_s     = '0;
        wr_in_range_s = ({1'b0, wr_addr} < DEPTH_C);
        rd_in_range_s = ({1'b0, rd_addr} < DEPTH_C);
        for (int i = 0; i < DEPTH; i++) begin
            wr_sel_s[i] = (wr_addr == ADDR_W'(i));
            rd_word_s   = rd_word_s | (mem_r[i] & {DATA_W{rd_addr == ADDR_W'(i)}});
        end
    end

    // Register storage: reset to RESET_VAL, byte-lane write on in-range address.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_en && wr_in_range_s && wr_sel_s[i] && wr_strb[b]) begin
                        mem_r[i][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

`ifdef RF_PARITY_EN
    logic [NB-1:0] par_r [DEPTH];
    logic [NB-1:0] rd_par_s;

    // Even parity bit of each byte lane of a word.
    function automatic logic [NB-1:0] lane_parity(input logic [DATA_W-1:0] word);
        logic [NB-1:0] p;
        for (int b = 0; b < NB; b++) begin
            p[b] = ^word[8*b +: 8];
        end
        return p;
    endfunction

    // Stored parity bits follow the same reset and lane-write rules as the data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                par_r[i] <= lane_parity(RESET_VAL);
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_en && wr_in_range_s && wr_sel_s[i] && wr_strb[b]) begin
                        par_r[i][b] <= ^wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Parity mux for the read address and lane mismatch detection.
    always_comb begin
        rd_par_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_par_s = rd_par_s | (par_r[i] & {NB{rd_addr == ADDR_W'(i)}});
        end
        rd_mismatch_s = |(lane_parity(rd_word_s) ^ rd_par_s);
    end
`else
    assign rd_mismatch_s = 1'b0;
`endif

    // Read pipeline stage; outputs are zero on any cycle without a delivered read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
            rd_err_r   <= 1'b0;
            rd_perr_r  <= 1'b0;
        end else if (rd_en) begin
            rd_valid_r <= 1'b1;
            if (rd_in_range_s) begin
                rd_data_r <= rd_word_s;
                rd_err_r  <= 1'b0;
                rd_perr_r <= rd_mismatch_s;
            end else begin
                rd_data_r <= ERR_VAL;
                rd_err_r  <= 1'b1;
                rd_perr_r <= 1'b0;
            end
        end else begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
            rd_err_r   <= 1'b0;
            rd_perr_r  <= 1'b0;
        end
    end

    // Write error flag pulses for one cycle after a dropped out-of-range write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_err_r <= 1'b0;
        end else begin
            wr_err_r <= wr_en && !wr_in_range_s;
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign rd_err   = rd_err_r;
    assign rd_perr  = rd_perr_r;
    assign wr_err   = wr_err_r;

endmodule
